// File: rtl/ov7670_capture_gen.sv
// ov7670_capture_gen
// -----------------------------------------------------------------------------
// Second-generation OV7670 DVP capture. Pairs 8-bit camera bytes into 16-bit
// pixels. Each kept pixel produces a one-cycle framebuffer write strobe with a
// linear address. Frames are gated by 'enable', and the block checks line and
// frame geometry.
//
// Optional build macro: OV7670_CAPTURE_TESTPAT_EN
//   When defined, adds input 'test_pat'. While it is high, the camera pixel is
//   replaced by {line_cnt[7:0], px_cnt[7:0]} and then formatted as usual.
//   Default build (macro undefined) has no such port.
//
// Ports
//   pclk        in   camera pixel clock, all logic on rising edge
//   rst_n       in   asynchronous active-low reset
//   enable      in   capture request, sampled at frame boundaries
//   vsync       in   camera vsync (active high)
//   href        in   camera href (active high)
//   d[7:0]      in   camera data byte
//   test_pat    in   (macro only) replace pixel data with counter pattern
//   addr        out  write address = kept-pixel index within the frame
//   dout[15:0]  out  formatted pixel, unused MSBs zero
//   we          out  one-cycle write strobe
//   frame_done  out  one-cycle pulse when a captured frame closes
//   frame_cnt   out  captured frame counter, wraps
//   geom_err    out  sticky geometry error
// -----------------------------------------------------------------------------
module ov7670_capture_gen #(
  parameter int ADDR_W   = 19,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int OUT_FMT  = 0,   // 0 RGB444, 1 RGB565, 2 Y8
  parameter int DECIM    = 0    // 1: keep even pixels of even lines
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
`ifdef OV7670_CAPTURE_TESTPAT_EN
  input  logic              test_pat,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              we,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              geom_err
);

  localparam int CNT_W = 16;
  localparam int MAX_I = ((H_ACTIVE >> DECIM) * (V_ACTIVE >> DECIM)) - 1;
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MAX_I);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SYNC   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [1:0]       state;
  logic             vs_q, hr_q, vs_qq, hr_qq;
  logic [7:0]       d_q, hi_q;
  logic             phase;
  logic             full;          // address MAX already written this frame
  logic [CNT_W-1:0] px_cnt, line_cnt;

  logic        in_act, vs_rise, vs_fall, hr_fall;
  logic        start, px_done, line_end, keep;
  logic [15:0] pix;

  function automatic logic [15:0] fmt(input logic [15:0] p);
    case (OUT_FMT)
      0:       fmt = {4'h0, p[15:12], p[10:7], p[4:1]};
      1:       fmt = p;
      default: fmt = {8'h00, p[7:0]};
    endcase
  endfunction

  assign in_act  = (state == S_ACTIVE);
  assign vs_rise = vs_q & ~vs_qq;
  assign vs_fall = ~vs_q & vs_qq;
  assign hr_fall = hr_qq & ~hr_q;
  assign start   = (state == S_SYNC) & vs_fall;
  // A vsync rise closes the frame at once: any pixel or line edge in the
  // same cycle belongs to the abandoned partial line.
  assign px_done  = in_act & ~vs_rise & hr_q & phase;
  assign line_end = in_act & ~vs_rise & hr_fall;
  assign keep     = (DECIM == 0) || (!px_cnt[0] && !line_cnt[0]);

`ifdef OV7670_CAPTURE_TESTPAT_EN
  assign pix = test_pat ? {line_cnt[7:0], px_cnt[7:0]} : {hi_q, d_q};
`else
  assign pix = {hi_q, d_q};
`endif

  // input registers plus one delayed copy of the strobes for edge detection
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q  <= 1'b0;
      hr_q  <= 1'b0;
      d_q   <= 8'h00;
      vs_qq <= 1'b0;
      hr_qq <= 1'b0;
    end else begin
      vs_q  <= vsync;
      hr_q  <= href;
      d_q   <= d;
      vs_qq <= vs_q;
      hr_qq <= hr_q;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (enable) state <= S_SYNC;
        S_SYNC:   if (vs_fall) state <= S_ACTIVE;
        S_ACTIVE: if (vs_rise) state <= enable ? S_SYNC : S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // byte phase: 0 = high byte, 1 = low byte completing the pixel
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      hi_q  <= 8'h00;
    end else begin
      phase <= (in_act && !vs_rise && hr_q) ? ~phase : 1'b0;
      if (in_act && hr_q && !phase) hi_q <= d_q;
    end
  end

  // pixel / line counters count every pixel and line, kept or not
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      px_cnt   <= '0;
      line_cnt <= '0;
    end else if (start) begin
      px_cnt   <= '0;
      line_cnt <= '0;
    end else if (line_end) begin
      px_cnt   <= '0;
      line_cnt <= line_cnt + CNT_W'(1);
    end else if (px_done) begin
      px_cnt   <= px_cnt + CNT_W'(1);
    end
  end

  // write strobe and data: one cycle after the low byte sits in d_q
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      we   <= 1'b0;
      dout <= 16'h0000;
    end else begin
      we <= px_done & keep & ~full;
      if (px_done && keep && !full) dout <= fmt(pix);
    end
  end

  // Address advances after each strobe. Once MAX is written it holds there
  // and 'full' blocks further writes for the rest of the frame.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      full <= 1'b0;
    end else if (start) begin
      addr <= '0;
      full <= 1'b0;
    end else if (we) begin
      if (addr == MAX_ADDR) full <= 1'b1;
      else                  addr <= addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_cnt  <= 8'h00;
    end else begin
      frame_done <= in_act & vs_rise;
      if (in_act && vs_rise) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      geom_err <= 1'b0;
    end else if (start && enable) begin
      geom_err <= 1'b0;
    end else if (in_act && vs_rise) begin
      if (line_cnt != CNT_W'(V_ACTIVE)) geom_err <= 1'b1;
    end else begin
      // wrong pixel count, or a trailing unpaired byte left in phase 1
      if (line_end && (px_cnt != CNT_W'(H_ACTIVE) || phase)) geom_err <= 1'b1;
      if (px_done && keep && full) geom_err <= 1'b1;
    end
  end

endmodule
